// File: rtl/mtm_alu_serializer.sv
`default_nettype none
// ============================================================================
//  Module   : mtm_alu_serializer
//  Purpose  : Transmit side of the ALU serial link. Latches one ALU result
//             (C word plus CTL byte) and shifts it out on sout as 11-bit byte
//             frames: start 0 | type | payload[7:0] MSB first | stop 1.
//             A normal result sends C[31:24]..C[7:0] as data frames followed by
//             CTL as a ctl frame. An error result (CTL[7]=1) sends only CTL.
//  Ports    : clk        - system clock, rising edge
//             rst        - asynchronous active-high reset
//             res_valid  - result on C/CTL is valid
//             res_ready  - serializer can accept a result (IDLE only)
//             C          - 32-bit ALU result word
//             CTL        - 8-bit ALU control/status byte
//             sout       - serial output line, idles high
//             busy       - high while a result is being transmitted
//             done       - one-cycle pulse after the final stop bit
//  Params   : BIT_CYCLES - clocks each serial bit is held on sout (>= 1)
//  Revision : 1.0 - initial release
// ============================================================================
module mtm_alu_serializer #(
   parameter int BIT_CYCLES = 1
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        res_valid,
   output logic        res_ready,
   input  logic [31:0] C,
   input  logic [7:0]  CTL,
   output logic        sout,
   output logic        busy,
   output logic        done
);

   localparam int              c_cnt_w    = $clog2(BIT_CYCLES) + 1;
   localparam logic [c_cnt_w-1:0] c_last_cyc = c_cnt_w'(BIT_CYCLES - 1);

   typedef enum logic [2:0] {
      ST_IDLE  = 3'd0,
      ST_START = 3'd1,
      ST_TYPE  = 3'd2,
      ST_DATA  = 3'd3,
      ST_STOP  = 3'd4
   } state_t;

   state_t               r_state, w_state_nxt;
   logic [2:0]           r_byte, w_byte_nxt;
   logic [2:0]           r_bit, w_bit_nxt;
   logic [c_cnt_w-1:0]   r_cyc, w_cyc_nxt;
   logic [31:0]          r_c_word, w_c_word_nxt;
   logic [7:0]           r_ctl_byte, w_ctl_byte_nxt;

   logic                 r_sout, r_busy, r_done, r_res_ready;
   logic                 w_sout_nxt, w_done_nxt;
   logic                 w_bit_end, w_last_byte;
   logic                 w_type_nxt;
   logic [7:0]           w_payload_nxt;

   assign sout      = r_sout;
   assign busy      = r_busy;
   assign done      = r_done;
   assign res_ready = r_res_ready;

   // Current bit has been held for its full period on this edge.
   assign w_bit_end   = (r_cyc == c_last_cyc);
   // Error results consist of a single ctl frame, so byte 0 is already last.
   assign w_last_byte = r_ctl_byte[7] || (r_byte == 3'd4);

   // ------------------------------------------------------------------------
   // State register
   // ------------------------------------------------------------------------
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state     <= ST_IDLE;
         r_byte      <= '0;
         r_bit       <= '0;
         r_cyc       <= '0;
         r_c_word    <= '0;
         r_ctl_byte  <= '0;
         r_sout      <= 1'b1;
         r_busy      <= 1'b0;
         r_done      <= 1'b0;
         r_res_ready <= 1'b1;
      end else begin
         r_state     <= w_state_nxt;
         r_byte      <= w_byte_nxt;
         r_bit       <= w_bit_nxt;
         r_cyc       <= w_cyc_nxt;
         r_c_word    <= w_c_word_nxt;
         r_ctl_byte  <= w_ctl_byte_nxt;
         r_sout      <= w_sout_nxt;
         r_busy      <= (w_state_nxt != ST_IDLE);
         r_done      <= w_done_nxt;
         r_res_ready <= (w_state_nxt == ST_IDLE);
      end
   end

   // ------------------------------------------------------------------------
   // Next-state logic
   // ------------------------------------------------------------------------
   always_comb begin
      w_state_nxt    = r_state;
      w_byte_nxt     = r_byte;
      w_bit_nxt      = r_bit;
      w_cyc_nxt      = r_cyc;
      w_c_word_nxt   = r_c_word;
      w_ctl_byte_nxt = r_ctl_byte;
      w_done_nxt     = 1'b0;

      case (r_state)
         ST_IDLE: begin
            if (res_valid && r_res_ready) begin
               w_state_nxt    = ST_START;
               w_byte_nxt     = 3'd0;
               w_bit_nxt      = 3'd7;
               w_cyc_nxt      = '0;
               w_c_word_nxt   = C;
               w_ctl_byte_nxt = CTL;
            end
         end

         default: begin
            if (!w_bit_end) begin
               w_cyc_nxt = r_cyc + 1'b1;
            end else begin
               w_cyc_nxt = '0;
               case (r_state)
                  ST_START: w_state_nxt = ST_TYPE;
                  ST_TYPE: begin
                     w_state_nxt = ST_DATA;
                     w_bit_nxt   = 3'd7;
                  end
                  ST_DATA: begin
                     if (r_bit == 3'd0) begin
                        w_state_nxt = ST_STOP;
                     end else begin
                        w_bit_nxt = r_bit - 1'b1;
                     end
                  end
                  ST_STOP: begin
                     if (w_last_byte) begin
                        w_state_nxt = ST_IDLE;
                        w_byte_nxt  = 3'd0;
                        w_done_nxt  = 1'b1;
                     end else begin
                        w_state_nxt = ST_START;
                        w_byte_nxt  = r_byte + 1'b1;
                     end
                  end
                  default: w_state_nxt = ST_IDLE;
               endcase
            end
         end
      endcase
   end

   // ------------------------------------------------------------------------
   // Serial bit for the coming cycle. Derived from the next-state values so
   // that sout can come straight from a flop and the start bit appears the
   // cycle after the accept edge.
   // ------------------------------------------------------------------------
   always_comb begin
      w_type_nxt = w_ctl_byte_nxt[7] || (w_byte_nxt == 3'd4);

      if (w_ctl_byte_nxt[7]) begin
         w_payload_nxt = w_ctl_byte_nxt;
      end else begin
         case (w_byte_nxt)
            3'd0:    w_payload_nxt = w_c_word_nxt[31:24];
            3'd1:    w_payload_nxt = w_c_word_nxt[23:16];
            3'd2:    w_payload_nxt = w_c_word_nxt[15:8];
            3'd3:    w_payload_nxt = w_c_word_nxt[7:0];
            default: w_payload_nxt = w_ctl_byte_nxt;
         endcase
      end

      case (w_state_nxt)
         ST_START: w_sout_nxt = 1'b0;
         ST_TYPE:  w_sout_nxt = w_type_nxt;
         ST_DATA:  w_sout_nxt = w_payload_nxt[w_bit_nxt];
         default:  w_sout_nxt = 1'b1;
      endcase
   end

endmodule
`default_nettype wire
